// File: rtl/node_rx.sv
// ---------------------------------------------------------------------------
// node_rx
// Inbound half of a NoC node. The router serialises each packet as four
// consecutive bytes on put_inbound/payload_inbound; this block reassembles
// them into a 32-bit packet, keeps packets addressed to this node in a small
// circular buffer and hands them to the consumer with a valid/ready handshake.
//
// Ports
//   clock            system clock, all state updates on the rising edge
//   reset            synchronous active-high reset
//   put_inbound      router presents a valid byte this cycle
//   payload_inbound  byte from the router
//   free_inbound     router may start a new packet (idle and a slot is free)
//   pkt_out          {sourceID, destID, data[23:0]} at the buffer head, 0 if empty
//   pkt_out_avail    pkt_out holds a valid packet
//   pkt_out_ready    consumer takes the head packet when it is available
//   rx_err           one-cycle pulse on a protocol violation
//   misroute         one-cycle pulse when a packet for another node is dropped
// ---------------------------------------------------------------------------
module node_rx #(
  parameter logic [3:0] NODEID = 4'd0,
  parameter int         DEPTH  = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        put_inbound,
  input  logic [7:0]  payload_inbound,
  output logic        free_inbound,
  output logic [31:0] pkt_out,
  output logic        pkt_out_avail,
  input  logic        pkt_out_ready,
  output logic        rx_err,
  output logic        misroute
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GOT0 = 2'd1,
    GOT1 = 2'd2,
    GOT2 = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      hdr_q, hdr_d;
  logic [7:0]      b1_q, b1_d;
  logic [7:0]      b2_q, b2_d;
  logic            rxErr_q, rxErr_d;
  logic            misroute_q, misroute_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wrPtr_q, wrPtr_d;
  logic [PW-1:0]   rdPtr_q, rdPtr_d;
  logic [31:0]     mem_q [DEPTH];

  logic            push;
  logic            pop;
  logic [31:0]     newPkt;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A grant is only issued from IDLE with a free slot, so the slot stays
  // reserved for the whole packet: pops during reception only free more room.
  assign free_inbound  = (state_q == IDLE) && (count_q < CW'(DEPTH));
  assign pkt_out_avail = (count_q != '0);
  assign pkt_out       = pkt_out_avail ? mem_q[rdPtr_q] : '0;
  assign rx_err        = rxErr_q;
  assign misroute      = misroute_q;

  // The final byte is taken straight from the input so the completed packet
  // can be written on the same edge that would have latched B3.
  assign newPkt = {hdr_q, b1_q, b2_q, payload_inbound};

  // Reassembly FSM and buffer bookkeeping. Error and misroute flags are
  // computed here and registered so they appear as clean one-cycle pulses.
  always_comb begin
    state_d    = state_q;
    hdr_d      = hdr_q;
    b1_d       = b1_q;
    b2_d       = b2_q;
    rxErr_d    = 1'b0;
    misroute_d = 1'b0;
    push       = 1'b0;

    case (state_q)
      IDLE: begin
        if (put_inbound) begin
          if (free_inbound) begin
            hdr_d   = payload_inbound;
            state_d = GOT0;
          end else begin
            rxErr_d = 1'b1;
          end
        end
      end
      GOT0: begin
        if (put_inbound) begin
          b1_d    = payload_inbound;
          state_d = GOT1;
        end else begin
          rxErr_d = 1'b1;
          state_d = IDLE;
        end
      end
      GOT1: begin
        if (put_inbound) begin
          b2_d    = payload_inbound;
          state_d = GOT2;
        end else begin
          rxErr_d = 1'b1;
          state_d = IDLE;
        end
      end
      GOT2: begin
        state_d = IDLE;
        if (put_inbound) begin
          if (hdr_q[3:0] == NODEID) begin
            push = 1'b1;
          end else begin
            misroute_d = 1'b1;
          end
        end else begin
          rxErr_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    pop     = pkt_out_avail && pkt_out_ready;
    count_d = count_q + CW'(push) - CW'(pop);
    wrPtr_d = push ? nextPtr(wrPtr_q) : wrPtr_q;
    rdPtr_d = pop  ? nextPtr(rdPtr_q) : rdPtr_q;
  end

  // Control state; reset drops any partial packet and empties the buffer.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      hdr_q      <= '0;
      b1_q       <= '0;
      b2_q       <= '0;
      rxErr_q    <= 1'b0;
      misroute_q <= 1'b0;
      count_q    <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
    end else begin
      state_q    <= state_d;
      hdr_q      <= hdr_d;
      b1_q       <= b1_d;
      b2_q       <= b2_d;
      rxErr_q    <= rxErr_d;
      misroute_q <= misroute_d;
      count_q    <= count_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
    end
  end

  // Packet storage needs no reset: pkt_out is masked while the buffer is empty.
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      mem_q[wrPtr_q] <= newPkt;
    end
  end

endmodule

// File: tb/tb_node_rx.sv
// ---------------------------------------------------------------------------
// tb_node_rx
// Directed self-checking bench for node_rx with NODEID=2, DEPTH=4. Inputs are
// driven 1 time unit after the rising edge and outputs are checked there too,
// well away from the next active edge.
// ---------------------------------------------------------------------------
module tb_node_rx;

  logic        clock;
  logic        reset;
  logic        put_inbound;
  logic [7:0]  payload_inbound;
  logic        free_inbound;
  logic [31:0] pkt_out;
  logic        pkt_out_avail;
  logic        pkt_out_ready;
  logic        rx_err;
  logic        misroute;

  int compareCount;
  int mismatchCount;

  node_rx #(.NODEID(4'd2), .DEPTH(4)) dut (
    .clock           (clock),
    .reset           (reset),
    .put_inbound     (put_inbound),
    .payload_inbound (payload_inbound),
    .free_inbound    (free_inbound),
    .pkt_out         (pkt_out),
    .pkt_out_avail   (pkt_out_avail),
    .pkt_out_ready   (pkt_out_ready),
    .rx_err          (rx_err),
    .misroute        (misroute)
  );

  // Free-running clock, period 10.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of router input and advance past the next rising edge.
  task automatic applyStimulus(input logic put, input logic [7:0] value);
    put_inbound     = put;
    payload_inbound = value;
    @(posedge clock);
    #1;
  endtask

  // Four consecutive put cycles, most significant byte first.
  task automatic sendPkt(input logic [31:0] p);
    applyStimulus(1'b1, p[31:24]);
    applyStimulus(1'b1, p[23:16]);
    applyStimulus(1'b1, p[15:8]);
    applyStimulus(1'b1, p[7:0]);
  endtask

  logic [31:0] expQ[$];
  logic [31:0] t2Pkts [4];
  logic [31:0] t5Pkts [8];
  logic [15:0] readyPattern;

  // Reset-value check shared by the start of the run and the mid-packet reset.
  task automatic checkResetState(input string tag);
    checkOutput({tag, "_free"},  32'(free_inbound),  32'd1);
    checkOutput({tag, "_avail"}, 32'(pkt_out_avail), 32'd0);
    checkOutput({tag, "_pkt"},   pkt_out,            32'd0);
    checkOutput({tag, "_err"},   32'(rx_err),        32'd0);
    checkOutput({tag, "_mis"},   32'(misroute),      32'd0);
  endtask

  initial begin
    int phase;
    int sent;
    logic putV;
    logic [7:0] byteV;
    logic [31:0] cur;
    logic modelFree;

    compareCount    = 0;
    mismatchCount   = 0;
    reset           = 1'b1;
    put_inbound     = 1'b0;
    payload_inbound = 8'h00;
    pkt_out_ready   = 1'b0;
    applyStimulus(1'b0, 8'h00);
    applyStimulus(1'b0, 8'h00);
    checkResetState("rst");
    reset = 1'b0;
    applyStimulus(1'b0, 8'h00);

    // Test 1: single packet, one-cycle visibility with ready held high.
    pkt_out_ready = 1'b1;
    applyStimulus(1'b1, 8'h12);
    checkOutput("t1_free_got0", 32'(free_inbound), 32'd0);
    applyStimulus(1'b1, 8'hAB);
    checkOutput("t1_free_got1", 32'(free_inbound), 32'd0);
    applyStimulus(1'b1, 8'hCD);
    checkOutput("t1_free_got2", 32'(free_inbound), 32'd0);
    checkOutput("t1_avail_early", 32'(pkt_out_avail), 32'd0);
    applyStimulus(1'b1, 8'hEF);
    checkOutput("t1_avail", 32'(pkt_out_avail), 32'd1);
    checkOutput("t1_pkt", pkt_out, 32'h12ABCDEF);
    checkOutput("t1_free_idle", 32'(free_inbound), 32'd1);
    applyStimulus(1'b0, 8'h00);
    checkOutput("t1_avail_after", 32'(pkt_out_avail), 32'd0);

    // Test 2: fill the buffer, reject an ungranted byte, drain in order.
    pkt_out_ready = 1'b0;
    t2Pkts[0] = 32'h12000001;
    t2Pkts[1] = 32'h32000002;
    t2Pkts[2] = 32'h52000003;
    t2Pkts[3] = 32'h72000004;
    for (int i = 0; i < 4; i++) begin
      sendPkt(t2Pkts[i]);
      applyStimulus(1'b0, 8'h00);
    end
    checkOutput("t2_free_full", 32'(free_inbound), 32'd0);
    checkOutput("t2_avail_full", 32'(pkt_out_avail), 32'd1);
    checkOutput("t2_head", pkt_out, t2Pkts[0]);
    applyStimulus(1'b1, 8'h12);
    checkOutput("t2_err_pulse", 32'(rx_err), 32'd1);
    checkOutput("t2_free_still", 32'(free_inbound), 32'd0);
    applyStimulus(1'b0, 8'h00);
    checkOutput("t2_err_clear", 32'(rx_err), 32'd0);
    pkt_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t2_drain_avail%0d", i), 32'(pkt_out_avail), 32'd1);
      checkOutput($sformatf("t2_drain_pkt%0d", i), pkt_out, t2Pkts[i]);
      applyStimulus(1'b0, 8'h00);
    end
    checkOutput("t2_empty", 32'(pkt_out_avail), 32'd0);
    checkOutput("t2_free_empty", 32'(free_inbound), 32'd1);

    // Test 3: aborted packet followed by an intact one.
    pkt_out_ready = 1'b0;
    applyStimulus(1'b1, 8'h12);
    applyStimulus(1'b1, 8'hAB);
    applyStimulus(1'b0, 8'h00);
    checkOutput("t3_err_pulse", 32'(rx_err), 32'd1);
    checkOutput("t3_avail", 32'(pkt_out_avail), 32'd0);
    checkOutput("t3_free", 32'(free_inbound), 32'd1);
    applyStimulus(1'b0, 8'h00);
    checkOutput("t3_err_clear", 32'(rx_err), 32'd0);
    sendPkt(32'h12112233);
    checkOutput("t3_next_avail", 32'(pkt_out_avail), 32'd1);
    checkOutput("t3_next_pkt", pkt_out, 32'h12112233);
    checkOutput("t3_next_err", 32'(rx_err), 32'd0);
    pkt_out_ready = 1'b1;
    applyStimulus(1'b0, 8'h00);
    checkOutput("t3_popped", 32'(pkt_out_avail), 32'd0);

    // Test 4: packet for node 3 is dropped with a misroute pulse.
    pkt_out_ready = 1'b0;
    sendPkt(32'h13445566);
    checkOutput("t4_misroute", 32'(misroute), 32'd1);
    checkOutput("t4_err", 32'(rx_err), 32'd0);
    checkOutput("t4_avail", 32'(pkt_out_avail), 32'd0);
    applyStimulus(1'b0, 8'h00);
    checkOutput("t4_mis_clear", 32'(misroute), 32'd0);
    checkOutput("t4_avail_after", 32'(pkt_out_avail), 32'd0);
    checkOutput("t4_free", 32'(free_inbound), 32'd1);

    // Test 5: back-to-back traffic with irregular ready against a queue model.
    for (int i = 0; i < 8; i++) begin
      t5Pkts[i] = {4'(i + 1), 4'd2, 8'(8'h40 + i), 8'(i * 17), 8'(8'hF0 - i)};
    end
    readyPattern = 16'b0110_1011_0011_1010;
    phase = 0;
    sent  = 0;
    expQ.delete();
    for (int cyc = 0; cyc < 80; cyc++) begin
      modelFree = (phase == 0) && (expQ.size() < 4);
      checkOutput($sformatf("t5_free_c%0d", cyc), 32'(free_inbound), 32'(modelFree));
      checkOutput($sformatf("t5_avail_c%0d", cyc), 32'(pkt_out_avail),
                  32'(expQ.size() != 0));
      if (expQ.size() != 0) begin
        checkOutput($sformatf("t5_pkt_c%0d", cyc), pkt_out, expQ[0]);
      end
      pkt_out_ready = readyPattern[cyc % 16];
      putV  = 1'b0;
      byteV = 8'h00;
      if (phase != 0 || (sent < 8 && modelFree)) begin
        cur   = t5Pkts[sent];
        putV  = 1'b1;
        byteV = cur[31 - 8 * phase -: 8];
      end
      applyStimulus(putV, byteV);
      if (expQ.size() != 0 && pkt_out_ready) begin
        void'(expQ.pop_front());
      end
      if (putV) begin
        if (phase == 3) begin
          expQ.push_back(t5Pkts[sent]);
          sent++;
        end
        phase = (phase + 1) % 4;
      end
    end
    checkOutput("t5_all_sent", 32'(sent), 32'd8);
    checkOutput("t5_drained", 32'(pkt_out_avail), 32'd0);

    // Test 6: reset while B2 is driven, with a stored packet pending.
    pkt_out_ready = 1'b0;
    sendPkt(32'h12777777);
    applyStimulus(1'b0, 8'h00);
    checkOutput("t6_pre_avail", 32'(pkt_out_avail), 32'd1);
    applyStimulus(1'b1, 8'h32);
    applyStimulus(1'b1, 8'h99);
    reset = 1'b1;
    applyStimulus(1'b1, 8'hAA);
    checkResetState("t6_rst");
    reset = 1'b0;
    applyStimulus(1'b0, 8'h00);
    checkOutput("t6_no_err", 32'(rx_err), 32'd0);
    checkOutput("t6_free", 32'(free_inbound), 32'd1);
    sendPkt(32'h52010203);
    checkOutput("t6_new_avail", 32'(pkt_out_avail), 32'd1);
    checkOutput("t6_new_pkt", pkt_out, 32'h52010203);
    pkt_out_ready = 1'b1;
    applyStimulus(1'b0, 8'h00);
    checkOutput("t6_single", 32'(pkt_out_avail), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
